// File: rtl/speed_boost_ctrl.sv
// Speed power-up controller: stacks boost levels up to MAX_LEVEL, times each level in frames, decays one level per expiry.
// Optional sprite warning blink near final expiry is enabled by defining SPEED_BOOST_BLINK_EN.
module speed_boost_ctrl #(
  parameter int MAX_LEVEL       = 2,
  parameter int DURATION_FRAMES = 300,
  parameter int TIMER_W         = 10,
  parameter int WARN_FRAMES     = 60,
  parameter int BLINK_PERIOD    = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               game_on,
  input  logic               powerup_pickup,
  input  logic               player_hit,
  output logic [1:0]         speed_level,
  output logic               boost_active,
  output logic [TIMER_W-1:0] frames_left,
  output logic               level_drop,
  output logic               speed_blink
);

  typedef enum logic [1:0] {IDLE_ST, NORMAL_ST, BOOST_ST, EXPIRE_ST} state_t;

  localparam logic [1:0]         MAX_LVL = 2'(MAX_LEVEL);
  localparam logic [TIMER_W-1:0] DUR     = TIMER_W'(DURATION_FRAMES);

  state_t             state, state_nxt;
  logic [1:0]         level, level_nxt, level_inc, level_dec;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic               drop_q, drop_nxt, boost_q;

  assign level_inc = (level >= MAX_LVL) ? MAX_LVL : level + 2'd1;
  assign level_dec = level - 2'd1;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE_ST;
      level   <= '0;
      timer   <= '0;
      drop_q  <= 1'b0;
      boost_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      level   <= level_nxt;
      timer   <= timer_nxt;
      drop_q  <= drop_nxt;
      boost_q <= (level_nxt != 2'd0);
    end
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    timer_nxt = timer;
    drop_nxt  = 1'b0;
    if (!game_on) begin
      state_nxt = IDLE_ST;
      level_nxt = '0;
      timer_nxt = '0;
    end else begin
      case (state)
        IDLE_ST: begin
          state_nxt = NORMAL_ST;
          level_nxt = '0;
          timer_nxt = '0;
        end
        NORMAL_ST: begin
          if (!player_hit && powerup_pickup) begin
            state_nxt = BOOST_ST;
            level_nxt = 2'd1;
            timer_nxt = DUR;
          end
        end
        BOOST_ST: begin
          if (player_hit) begin
            state_nxt = NORMAL_ST;
            level_nxt = '0;
            timer_nxt = '0;
          end else if (powerup_pickup) begin
            // pickup beats an expiring frame tick in the same cycle
            level_nxt = level_inc;
            timer_nxt = DUR;
          end else if (startOfFrame) begin
            timer_nxt = timer - TIMER_W'(1);
            if (timer == TIMER_W'(1)) state_nxt = EXPIRE_ST;
          end
        end
        EXPIRE_ST: begin
          if (player_hit) begin
            state_nxt = NORMAL_ST;
            level_nxt = '0;
            timer_nxt = '0;
          end else begin
            drop_nxt = 1'b1;
            if (powerup_pickup) begin
              // decrement followed by pickup nets to the current level
              state_nxt = BOOST_ST;
              level_nxt = level;
              timer_nxt = DUR;
            end else if (level_dec != 2'd0) begin
              state_nxt = BOOST_ST;
              level_nxt = level_dec;
              timer_nxt = DUR;
            end else begin
              state_nxt = NORMAL_ST;
              level_nxt = '0;
              timer_nxt = '0;
            end
          end
        end
        default: begin
          state_nxt = IDLE_ST;
          level_nxt = '0;
          timer_nxt = '0;
        end
      endcase
    end
  end

  assign speed_level  = level;
  assign frames_left  = timer;
  assign boost_active = boost_q;
  assign level_drop   = drop_q;

`ifdef SPEED_BOOST_BLINK_EN
  localparam int DIV_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  logic [DIV_W-1:0] div;
  logic             blink_q, blink_win;

  assign blink_win = game_on && !player_hit && (state == BOOST_ST) && (level == 2'd1) &&
                     (timer <= TIMER_W'(WARN_FRAMES));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div     <= '0;
      blink_q <= 1'b0;
    end else if (!blink_win) begin
      div     <= '0;
      blink_q <= 1'b0;
    end else if (startOfFrame) begin
      if (div == DIV_W'(BLINK_PERIOD - 1)) begin
        div     <= '0;
        blink_q <= ~blink_q;
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  assign speed_blink = blink_q;
`else
  assign speed_blink = 1'b0;
`endif

endmodule

// File: doc/speed_boost_ctrl.md
Name: speed_boost_ctrl

Overview:
- Configures the player movement block's speed level from collected speed power-ups.
- Stacks boosts up to MAX_LEVEL, times each level in frames and decays one level per expiry.
- Clears on player death or game stop.
- One instance per player, between the power-up pickup logic and the speed_level input of the player movement block.

Parameters:
- MAX_LEVEL, 2, highest speed level; range 1..3.
- DURATION_FRAMES, 300, frames each level lasts (10 s at 30 Hz); must be >= 1.
- TIMER_W, 10, width of the frame countdown; must hold DURATION_FRAMES.
- WARN_FRAMES, 60, blink window before expiry (optional feature only).
- BLINK_PERIOD, 4, frames per blink half-period (optional feature only).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-clock pulse per frame
- game_on  in  1  game running
- powerup_pickup  in  1  one-clock pulse, speed power-up collected
- player_hit  in  1  one-clock pulse, player killed
- speed_level  out  2  to player movement speed_level input
- boost_active  out  1  high when speed_level != 0
- frames_left  out  TIMER_W  remaining frames at current level; 0 when no boost
- level_drop  out  1  one-clock pulse when the level decrements through expiry
- speed_blink  out  1  warning blink for the sprite

Behaviour:
- Reset (async, resetN low), all outputs:
  - speed_level=0, boost_active=0, frames_left=0, level_drop=0, speed_blink=0.
  - State IDLE_ST.
- All outputs are registered, so every response appears on the clock edge after its cause.
- States:
  - IDLE_ST: level 0, timer 0; inputs other than game_on are ignored. game_on=1 -> NORMAL_ST.
  - NORMAL_ST: level 0. powerup_pickup -> level=1, timer=DURATION_FRAMES, go to BOOST_ST.
  - BOOST_ST: level >= 1.
    - startOfFrame decrements the timer.
    - startOfFrame with timer==1 -> timer=0, go to EXPIRE_ST.
    - powerup_pickup -> level=min(level+1, MAX_LEVEL), timer=DURATION_FRAMES.
    - At MAX_LEVEL a pickup only reloads the timer; the level saturates and never wraps.
  - EXPIRE_ST (1 cycle):
    - level decrements and level_drop=1 for this transition only.
    - New level > 0: timer=DURATION_FRAMES, go to BOOST_ST.
    - New level = 0: go to NORMAL_ST.
- Priority within one cycle, highest first:
  1. game_on=0: go to IDLE_ST next edge, all outputs cleared, from any state.
  2. player_hit: level=0, timer=0, go to NORMAL_ST, no level_drop, pickup in the same cycle discarded.
  3. powerup_pickup.
  4. startOfFrame.
- Pickup and the expiring startOfFrame (timer==1) in the same cycle: the pickup wins. Level increments, timer reloads, no expiry, no level_drop.
- Pickup during EXPIRE_ST: applied to the post-decrement level (net level unchanged), timer reloads, state BOOST_ST, level_drop still pulses.
- startOfFrame during EXPIRE_ST is not counted.
- frames_left mirrors the timer register. boost_active is registered as (next level != 0).
- speed_level is held stable between edges. The movement block samples it only once per frame, so mid-frame changes are legal.
- game_on dropping mid-boost, then returning: the player restarts at level 0.

Optional Feature:
- Macro: SPEED_BOOST_BLINK_EN.
- Defined:
  - A frame divider counts startOfFrame pulses modulo BLINK_PERIOD.
  - speed_blink toggles each wrap while state=BOOST_ST, level=1 and frames_left <= WARN_FRAMES.
  - Otherwise speed_blink=0 and the divider clears.
- Not defined: speed_blink tied 0 and no divider logic.

Test Plan:
- Reset, game_on=1, one pickup -> speed_level=1 next edge, frames_left=300, boost_active=1.
- 300 startOfFrame pulses -> EXPIRE_ST, level_drop one clock, speed_level=0, frames_left=0.
- Three pickups 10 clocks apart -> speed_level 1,2,2 (saturates), frames_left=300 after each. Then 300 frames -> level 1 with frames_left=300 reloaded; 300 more -> level 0. Two level_drop pulses total.
- Level 1, frames_left=1, pickup and startOfFrame in the same clock -> speed_level=2, frames_left=300, no level_drop.
- Level 2 mid-count, player_hit and pickup in the same clock -> speed_level=0, frames_left=0, NORMAL_ST. Separately, game_on=0 at level 2 -> all outputs 0 next edge; game_on=1 plus one pickup -> level 1.
- With SPEED_BOOST_BLINK_EN, level 1, frames_left 60->0 -> speed_blink toggles every 4 frames. Same run at level 2 -> speed_blink stays 0. Assert resetN mid-boost -> all outputs 0 immediately, asynchronously.
